seg_scan_ctrl: RTL and testbench

Scan controller and write arbiter for the eight-digit seven-segment display. Two requesters write per-digit values into an internal digit store through a 2-way round-robin arbiter. A prescaled scan sequencer time-multiplexes the store onto the `num`/`seg_en` inputs of the `seg` decoder, enabling one digit at a time.

---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_req_if.sv | 13 +
 rtl/seg_rr_arb.sv | 35 +++
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

    localparam int SEG_DIGITS    = 8;
    localparam int SEG_BLANK_BIT = 3;

    typedef logic [2:0] seg_idx_t;
    typedef logic [3:0] seg_val_t;

    localparam seg_val_t SEG_RESET_VAL = 4'b1000;

    function automatic logic [SEG_DIGITS-1:0] seg_onehot(input seg_idx_t idx);
        logic [SEG_DIGITS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/seg_req_if.sv
// Write-request channel: one digit index/value per handshake (valid & ready).
interface seg_req_if;
    import seg_pkg::*;

    logic     valid;
    logic     ready;
    seg_idx_t idx;
    seg_val_t val;

    modport master (output valid, output idx, output val, input ready);
    modport slave  (input valid, input idx, input val, output ready);

endinterface

// File: rtl/seg_rr_arb.sv
// Two-way round-robin arbiter; priority flips to the other side after every grant.
module seg_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio_reg;
    logic prio_next;

    always_comb begin
        grant     = 2'b00;
        prio_next = prio_reg;
        // Grants are suppressed while reset is held so nothing can handshake.
        if (!rst) begin
            grant[0] = valid[0] & (~valid[1] | ~prio_reg);
            grant[1] = valid[1] & (~valid[0] |  prio_reg);
        end
        if (grant[0]) begin
            prio_next = 1'b1;
        end else if (grant[1]) begin
            prio_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_reg <= 1'b0;
        end else begin
            prio_reg <= prio_next;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Digit store, scan sequencer and output registers for an 8-digit display.
// Optional blinking is built only when SEG_BLINK_EN is defined.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_req_if.slave              req0,
    seg_req_if.slave              req1,
    input  logic [SEG_DIGITS-1:0] blink_mask,
    output logic [2:0]            num,
    output logic [SEG_DIGITS-1:0] seg_en,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(SCAN_DIV);

    logic [1:0] grant;

    seg_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1.valid, req0.valid}),
        .grant (grant)
    );

    assign req0.ready = grant[0];
    assign req1.ready = grant[1];

    logic     wr_en;
    seg_idx_t wr_idx;
    seg_val_t wr_val;

    always_comb begin
        wr_en  = |grant;
        wr_idx = req0.idx;
        wr_val = req0.val;
        if (grant[1]) begin
            wr_idx = req1.idx;
            wr_val = req1.val;
        end
    end

    seg_val_t [SEG_DIGITS-1:0] store_q;

    generate
        for (genvar gi = 0; gi < SEG_DIGITS; gi++) begin : g_store
            seg_val_t entry_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    entry_reg <= SEG_RESET_VAL;
                end else if (wr_en && (wr_idx == seg_idx_t'(gi))) begin
                    entry_reg <= wr_val;
                end
            end

            assign store_q[gi] = entry_reg;
        end
    endgenerate

    logic [CNT_W-1:0] cnt_reg;
    seg_idx_t         ptr_reg;
    logic             cnt_last;
    logic             frame_last;

    assign cnt_last   = (cnt_reg == CNT_W'(SCAN_DIV - 1));
    assign frame_last = cnt_last && (ptr_reg == seg_idx_t'(SEG_DIGITS - 1));

    // The 3-bit digit pointer wraps 7 -> 0 on its own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
            ptr_reg <= '0;
        end else if (cnt_last) begin
            cnt_reg <= '0;
            ptr_reg <= ptr_reg + 3'd1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    logic blink_sup;

`ifdef SEG_BLINK_EN
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BLINK_W-1:0] frame_cnt_reg;
    logic               phase_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (frame_last) begin
            if (frame_cnt_reg == BLINK_W'(BLINK_DIV - 1)) begin
                frame_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    assign blink_sup = phase_reg & blink_mask[ptr_reg];
`else
    // Keeps the mask port and blink divider in the netlist-free build tidy.
    logic unused_blink;
    assign unused_blink = (^blink_mask) ^ (BLINK_DIV < 1);
    assign blink_sup    = 1'b0;
`endif

    seg_val_t cur_val;
    assign cur_val = store_q[ptr_reg];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num        <= '0;
            seg_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            num        <= cur_val[2:0];
            seg_en     <= (!cur_val[SEG_BLANK_BIT] && !blink_sup) ? seg_onehot(ptr_reg) : '0;
            frame_done <= frame_last;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: writes are queued with their visibility cycle,
// and every scanned output cycle is compared against the expected digit image.
module tb_seg_scan_ctrl;
    import seg_pkg::*;

    localparam int SD = 4;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] blink_mask = 8'h00;
    logic [2:0] num;
    logic [7:0] seg_en;
    logic       frame_done;

    seg_req_if r0 ();
    seg_req_if r1 ();

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0       (r0),
        .req1       (r1),
        .blink_mask (blink_mask),
        .num        (num),
        .seg_en     (seg_en),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; read at the negedge it equals the output cycle index.
    int cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int compared   = 0;
    int mismatched = 0;

    typedef struct { int vis; seg_idx_t idx; seg_val_t val; } wr_t;
    typedef struct { logic [2:0] num; logic [7:0] seg_en; logic fd; } exp_t;

    wr_t      pend_q[$];
    exp_t     exp_q[$];
    seg_val_t ref_store [SEG_DIGITS];
    logic     prio_m;

    function automatic exp_t expect_at(input int k);
        exp_t     e;
        int       p;
        int       c;
        seg_val_t v;
        logic     sup;
        e.num    = 3'd0;
        e.seg_en = 8'd0;
        e.fd     = 1'b0;
        if (k >= 1) begin
            p   = ((k - 1) / SD) % 8;
            c   = (k - 1) % SD;
            v   = ref_store[p];
            sup = 1'b0;
`ifdef SEG_BLINK_EN
            sup = blink_mask[p] && ((((k - 1) / (8 * SD)) / BD) % 2 == 1);
`endif
            e.num    = v[2:0];
            e.seg_en = (v[3] || sup) ? 8'd0 : 8'(1 << p);
            e.fd     = (p == 7) && (c == SD - 1);
        end
        return e;
    endfunction

    task automatic advance();
        @(negedge clk);
        while (pend_q.size() > 0 && pend_q[0].vis <= cyc) begin
            ref_store[pend_q[0].idx] = pend_q[0].val;
            void'(pend_q.pop_front());
        end
        exp_q.push_back(expect_at(cyc));
    endtask

    task automatic drive_reqs(input logic v0, input seg_idx_t i0, input seg_val_t d0,
                              input logic v1, input seg_idx_t i1, input seg_val_t d1,
                              output logic g0, output logic g1);
        r0.valid = v0; r0.idx = i0; r0.val = d0;
        r1.valid = v1; r1.idx = i1; r1.val = d1;
        g0 = v0 && (!v1 || !prio_m);
        g1 = v1 && (!v0 || prio_m);
        if (g0) begin
            pend_q.push_back('{vis: cyc + 2, idx: i0, val: d0});
            prio_m = 1'b1;
            $display("write req0 idx=%0d val=%b cyc=%0d", i0, d0, cyc);
        end else if (g1) begin
            pend_q.push_back('{vis: cyc + 2, idx: i1, val: d1});
            prio_m = 1'b0;
            $display("write req1 idx=%0d val=%b cyc=%0d", i1, d1, cyc);
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0.valid = 1'b0; r0.idx = '0; r0.val = '0;
        r1.valid = 1'b0; r1.idx = '0; r1.val = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        foreach (ref_store[j]) ref_store[j] = 4'b1000;
        pend_q.delete();
        exp_q.delete();
        prio_m = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        r0.valid = 1'b1; r0.idx = 3'd0; r0.val = 4'd1;
        r1.valid = 1'b1; r1.idx = 3'd1; r1.val = 4'd2;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if ({r0.ready, r1.ready} !== 2'b00) begin
            mismatched++;
            $display("FAIL reset_ready got=%b want=00", {r0.ready, r1.ready});
        end
        compared++;
        if ({num, seg_en, frame_done} !== 12'd0) begin
            mismatched++;
            $display("FAIL reset_out got num=%0d seg_en=%b fd=%b want 0/0/0", num, seg_en, frame_done);
        end
        do_reset();
        for (int i = 0; i < 70; i++) begin
            advance();
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || seg_en !== e.seg_en || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL scan_idle cyc=%0d got num=%0d seg_en=%b fd=%b want num=%0d seg_en=%b fd=%b",
                         cyc, num, seg_en, frame_done, e.num, e.seg_en, e.fd);
            end
        end
    endtask

    task automatic test_write();
        exp_t e;
        logic g0, g1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            advance();
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || seg_en !== e.seg_en || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL scan_write cyc=%0d got num=%0d seg_en=%b fd=%b want num=%0d seg_en=%b fd=%b",
                         cyc, num, seg_en, frame_done, e.num, e.seg_en, e.fd);
            end
            if (i == 3) drive_reqs(1'b1, 3'd2, 4'b0101, 1'b0, 3'd0, 4'd0, g0, g1);
            else        drive_reqs(1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 4'd0, g0, g1);
            if (i == 3) begin
                compared++;
                if ({r0.ready, r1.ready} !== {g0, g1}) begin
                    mismatched++;
                    $display("FAIL write_grant cyc=%0d got=%b want=%b", cyc, {r0.ready, r1.ready}, {g0, g1});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic g0, g1;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            advance();
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || seg_en !== e.seg_en || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL scan_arb cyc=%0d got num=%0d seg_en=%b fd=%b want num=%0d seg_en=%b fd=%b",
                         cyc, num, seg_en, frame_done, e.num, e.seg_en, e.fd);
            end
            if (i >= 1 && i <= 4)
                drive_reqs(1'b1, seg_idx_t'(i - 1), seg_val_t'(i), 1'b1, seg_idx_t'(i + 3), seg_val_t'(i + 2), g0, g1);
            else if (i == 5 || i == 6)
                drive_reqs(1'b1, 3'd3, 4'b0001, 1'b1, 3'd3, 4'b0110, g0, g1);
            else
                drive_reqs(1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 4'd0, g0, g1);
            compared++;
            if ({r0.ready, r1.ready} !== {g0, g1}) begin
                mismatched++;
                $display("FAIL arb_grant cyc=%0d got=%b want=%b", cyc, {r0.ready, r1.ready}, {g0, g1});
            end
        end
    endtask

    task automatic test_blank();
        exp_t e;
        logic g0, g1;
        do_reset();
        for (int i = 0; i < 80; i++) begin
            advance();
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || seg_en !== e.seg_en || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL scan_blank cyc=%0d got num=%0d seg_en=%b fd=%b want num=%0d seg_en=%b fd=%b",
                         cyc, num, seg_en, frame_done, e.num, e.seg_en, e.fd);
            end
            if (i == 1)       drive_reqs(1'b1, 3'd2, 4'b0101, 1'b0, 3'd0, 4'd0, g0, g1);
            else if (i == 30) drive_reqs(1'b0, 3'd0, 4'd0, 1'b1, 3'd2, 4'b1011, g0, g1);
            else              drive_reqs(1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 4'd0, g0, g1);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        logic g0, g1;
        do_reset();
        for (int i = 0; i < 22; i++) begin
            advance();
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || seg_en !== e.seg_en || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL scan_pre_rst cyc=%0d got num=%0d seg_en=%b fd=%b want num=%0d seg_en=%b fd=%b",
                         cyc, num, seg_en, frame_done, e.num, e.seg_en, e.fd);
            end
            if (i == 1)      drive_reqs(1'b1, 3'd1, 4'b0011, 1'b0, 3'd0, 4'd0, g0, g1);
            else if (i == 2) drive_reqs(1'b0, 3'd0, 4'd0, 1'b1, 3'd5, 4'b0010, g0, g1);
            else             drive_reqs(1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 4'd0, g0, g1);
        end
        // A handshake is in flight when reset hits; it must not land.
        r0.valid = 1'b1; r0.idx = 3'd2; r0.val = 4'b0101;
        #1;
        compared++;
        if (r0.ready !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_ready got=%b want=1", r0.ready);
        end
        #1;
        rst = 1'b1;
        #1;
        compared++;
        if ({num, seg_en, frame_done, r0.ready, r1.ready} !== 14'd0) begin
            mismatched++;
            $display("FAIL mid_rst_out got num=%0d seg_en=%b fd=%b rdy=%b want all 0",
                     num, seg_en, frame_done, {r0.ready, r1.ready});
        end
        do_reset();
        for (int i = 0; i < 40; i++) begin
            advance();
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || seg_en !== e.seg_en || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL scan_post_rst cyc=%0d got num=%0d seg_en=%b fd=%b want num=%0d seg_en=%b fd=%b",
                         cyc, num, seg_en, frame_done, e.num, e.seg_en, e.fd);
            end
            if (i == 0) begin
                drive_reqs(1'b1, 3'd4, 4'b0010, 1'b1, 3'd4, 4'b0001, g0, g1);
                compared++;
                if ({r0.ready, r1.ready} !== 2'b10) begin
                    mismatched++;
                    $display("FAIL post_rst_tie got=%b want=10", {r0.ready, r1.ready});
                end
            end else begin
                drive_reqs(1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 4'd0, g0, g1);
            end
        end
    endtask

`ifdef SEG_BLINK_EN
    task automatic test_blink();
        exp_t e;
        logic g0, g1;
        blink_mask = 8'h01;
        do_reset();
        for (int i = 0; i < 170; i++) begin
            advance();
            e = exp_q.pop_front();
            compared++;
            if (num !== e.num || seg_en !== e.seg_en || frame_done !== e.fd) begin
                mismatched++;
                $display("FAIL scan_blink cyc=%0d got num=%0d seg_en=%b fd=%b want num=%0d seg_en=%b fd=%b",
                         cyc, num, seg_en, frame_done, e.num, e.seg_en, e.fd);
            end
            if (i == 1) drive_reqs(1'b1, 3'd0, 4'b0111, 1'b0, 3'd0, 4'd0, g0, g1);
            else        drive_reqs(1'b0, 3'd0, 4'd0, 1'b0, 3'd0, 4'd0, g0, g1);
        end
        blink_mask = 8'h00;
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_blank();
        test_reset_mid();
`ifdef SEG_BLINK_EN
        test_blink();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
